// File: rtl/vx_writeback_arbiter_if.sv
// rtl/vx_writeback_arbiter_if.sv - Bundle of unit-side commit handshake and writeback-side beat signals
//
// Purpose: carries the per-unit commit handshake (in_valid/in_ready/in_data) and the
// registered writeback beat plus retire counter between the arbiter and its neighbours.
// Optional macro WB_ARB_PERF_EN adds perf_stalls.
//
// Port summary (signals of the bundle):
//   in_valid  [NUM_INPUTS]      unit i presents a beat
//   in_ready  [NUM_INPUTS]      beat of unit i accepted this cycle
//   in_data   [NUM_INPUTS*DW]   {uuid,wid,PC,tmask,rd,wb,data,sop,eop} per unit, unit 0 in LSBs
//   wb_*                        registered writeback beat
//   retire_cnt[CNT_W]           instructions retired since reset
//   perf_stalls[CNT_W]          (WB_ARB_PERF_EN only) stalled-valid cycles
// Modports: master = arbiter side, slave = execute units / issue stage side.

interface vx_writeback_arbiter_if #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int UUID_W      = 44,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
);
    localparam int DW = UUID_W + NW_BITS + PC_W + NUM_THREADS + NR_BITS + 1
                      + NUM_THREADS * XLEN + 2;

    logic [NUM_INPUTS-1:0]         in_valid;
    logic [NUM_INPUTS-1:0]         in_ready;
    logic [NUM_INPUTS*DW-1:0]      in_data;

    logic                          wb_valid;
    logic [UUID_W-1:0]             wb_uuid;
    logic [NW_BITS-1:0]            wb_wid;
    logic [PC_W-1:0]               wb_PC;
    logic [NUM_THREADS-1:0]        wb_tmask;
    logic [NR_BITS-1:0]            wb_rd;
    logic [NUM_THREADS*XLEN-1:0]   wb_data;
    logic                          wb_sop;
    logic                          wb_eop;
    logic [CNT_W-1:0]              retire_cnt;
`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0]              perf_stalls;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
        output retire_cnt, perf_stalls
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
        input  retire_cnt, perf_stalls
    );
`else
    modport master (
        input  in_valid, in_data,
        output in_ready,
        output wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
        output retire_cnt
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  wb_valid, wb_uuid, wb_wid, wb_PC, wb_tmask, wb_rd, wb_data, wb_sop, wb_eop,
        input  retire_cnt
    );
`endif

endinterface

// File: rtl/vx_writeback_arbiter.sv
// rtl/vx_writeback_arbiter.sv - Round-robin writeback arbiter for one issue slot
//
// Purpose: collects commit beats from NUM_INPUTS execute units, grants one per cycle
// round-robin (locking on multi-beat packets until eop), registers the granted beat onto
// the writeback outputs one cycle later and counts retired instructions.
// Optional macro WB_ARB_PERF_EN adds the perf_stalls counter.
//
// Ports:
//   clk     in  clock
//   reset   in  synchronous, active-high
//   wb_if   vx_writeback_arbiter_if.master: in_valid/in_ready/in_data from the units,
//           wb_* registered beat, retire_cnt (and perf_stalls when enabled)

module vx_writeback_arbiter #(
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int UUID_W      = 44,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    vx_writeback_arbiter_if.master  wb_if
);
    localparam int DW = UUID_W + NW_BITS + PC_W + NUM_THREADS + NR_BITS + 1
                      + NUM_THREADS * XLEN + 2;
    localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    // Field offsets inside one unit's packed beat (eop in bit 0).
    localparam int OFF_EOP   = 0;
    localparam int OFF_SOP   = 1;
    localparam int OFF_DATA  = 2;
    localparam int OFF_WB    = OFF_DATA + NUM_THREADS * XLEN;
    localparam int OFF_RD    = OFF_WB + 1;
    localparam int OFF_TMASK = OFF_RD + NR_BITS;
    localparam int OFF_PC    = OFF_TMASK + NUM_THREADS;
    localparam int OFF_WID   = OFF_PC + PC_W;
    localparam int OFF_UUID  = OFF_WID + NW_BITS;

    logic [PTR_W-1:0]              r_ptr;
    logic                          r_locked;
    logic [PTR_W-1:0]              r_lock_id;

    logic                          r_wb_valid;
    logic [UUID_W-1:0]             r_wb_uuid;
    logic [NW_BITS-1:0]            r_wb_wid;
    logic [PC_W-1:0]               r_wb_pc;
    logic [NUM_THREADS-1:0]        r_wb_tmask;
    logic [NR_BITS-1:0]            r_wb_rd;
    logic [NUM_THREADS*XLEN-1:0]   r_wb_data;
    logic                          r_wb_sop;
    logic                          r_wb_eop;
    logic [CNT_W-1:0]              r_retire;

    logic [NUM_INPUTS-1:0]         w_grant;
    logic [PTR_W-1:0]              w_sel;
    logic [PTR_W-1:0]              w_ptr_next;
    logic                          w_xfer;
    logic [DW-1:0]                 w_beat;

    // Grant logic. Reset forces all grants low so units see no acceptance while
    // the slot is being reset. A locked unit that drops valid gets no grant and
    // nobody else is served in its place.
    always_comb begin
        int idx;
        w_grant = '0;
        w_sel   = '0;
        idx     = 0;
        if (!reset) begin
            if (r_locked) begin
                w_grant[r_lock_id] = wb_if.in_valid[r_lock_id];
                w_sel              = r_lock_id;
            end else begin
                // Scan from the farthest candidate down so the last hit is the
                // first valid unit at or after the pointer.
                for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                    idx = int'(r_ptr) + k;
                    if (idx >= NUM_INPUTS) begin
                        idx = idx - NUM_INPUTS;
                    end
                    if (wb_if.in_valid[idx]) begin
                        w_grant      = '0;
                        w_grant[idx] = 1'b1;
                        w_sel        = PTR_W'(idx);
                    end
                end
            end
        end
    end

    assign w_xfer     = |w_grant;
    assign w_beat     = wb_if.in_data[int'(w_sel) * DW +: DW];
    assign w_ptr_next = (int'(w_sel) == NUM_INPUTS - 1) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_lock_id  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_uuid  <= '0;
            r_wb_wid   <= '0;
            r_wb_pc    <= '0;
            r_wb_tmask <= '0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_sop   <= 1'b0;
            r_wb_eop   <= 1'b0;
            r_retire   <= '0;
        end else begin
            r_wb_valid <= w_xfer & w_beat[OFF_WB];
            // Data fields only move when a real writeback is issued.
            if (w_xfer && w_beat[OFF_WB]) begin
                r_wb_uuid  <= w_beat[OFF_UUID +: UUID_W];
                r_wb_wid   <= w_beat[OFF_WID +: NW_BITS];
                r_wb_pc    <= w_beat[OFF_PC +: PC_W];
                r_wb_tmask <= w_beat[OFF_TMASK +: NUM_THREADS];
                r_wb_rd    <= w_beat[OFF_RD +: NR_BITS];
                r_wb_data  <= w_beat[OFF_DATA +: NUM_THREADS * XLEN];
                r_wb_sop   <= w_beat[OFF_SOP];
                r_wb_eop   <= w_beat[OFF_EOP];
            end
            if (w_xfer) begin
                if (w_beat[OFF_EOP]) begin
                    r_locked <= 1'b0;
                    r_ptr    <= w_ptr_next;
                    r_retire <= r_retire + CNT_W'(1);
                end else begin
                    r_locked  <= 1'b1;
                    r_lock_id <= w_sel;
                end
            end
        end
    end

    assign wb_if.in_ready   = w_grant;
    assign wb_if.wb_valid   = r_wb_valid;
    assign wb_if.wb_uuid    = r_wb_uuid;
    assign wb_if.wb_wid     = r_wb_wid;
    assign wb_if.wb_PC      = r_wb_pc;
    assign wb_if.wb_tmask   = r_wb_tmask;
    assign wb_if.wb_rd      = r_wb_rd;
    assign wb_if.wb_data    = r_wb_data;
    assign wb_if.wb_sop     = r_wb_sop;
    assign wb_if.wb_eop     = r_wb_eop;
    assign wb_if.retire_cnt = r_retire;

`ifdef WB_ARB_PERF_EN
    logic [CNT_W-1:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else begin
            r_perf_stalls <= r_perf_stalls
                           + CNT_W'($countones(wb_if.in_valid & ~w_grant));
        end
    end

    assign wb_if.perf_stalls = r_perf_stalls;
`endif

`ifndef SYNTHESIS
    a_ready_onehot0: assert property (@(posedge clk) $onehot0(w_grant));
    a_no_sop_while_locked: assert property (@(posedge clk) disable iff (reset)
        !(r_locked && w_xfer && w_beat[OFF_SOP]));
`endif

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// tb/tb_vx_writeback_arbiter.sv - Scoreboard bench for vx_writeback_arbiter

module tb_vx_writeback_arbiter;
    localparam int NI   = 4;
    localparam int NT   = 4;
    localparam int XL   = 32;
    localparam int NW   = 2;
    localparam int NR   = 6;
    localparam int UW   = 44;
    localparam int PCW  = 32;
    localparam int CW   = 32;
    localparam int DW   = UW + NW + PCW + NT + NR + 1 + NT * XL + 2;
    localparam int FW   = DW - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_writeback_arbiter_if #(
        .NUM_INPUTS(NI), .NUM_THREADS(NT), .XLEN(XL), .NW_BITS(NW),
        .NR_BITS(NR), .UUID_W(UW), .PC_W(PCW), .CNT_W(CW)
    ) bus ();

    vx_writeback_arbiter #(
        .NUM_INPUTS(NI), .NUM_THREADS(NT), .XLEN(XL), .NW_BITS(NW),
        .NR_BITS(NR), .UUID_W(UW), .PC_W(PCW), .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wb_if (bus)
    );

    typedef struct {
        logic [UW-1:0]    uuid;
        logic [NW-1:0]    wid;
        logic [PCW-1:0]   pc;
        logic [NT-1:0]    tmask;
        logic [NR-1:0]    rd;
        logic             wb;
        logic [NT*XL-1:0] data;
        logic             sop;
        logic             eop;
        int               pre_gap;
    } beat_t;

    typedef struct {
        logic          valid;
        logic [FW-1:0] f;
        logic [CW-1:0] retire;
    } exp_t;

    beat_t uq [NI][$];
    bit    pres [NI];
    exp_t  sbq [$];

    int            m_ptr;
    int            m_lock;
    logic [CW-1:0] m_retire;
    logic [FW-1:0] m_last;

    bit rst_req;
    int cyc;
    int checks;
    int failures;

    function automatic logic [FW-1:0] fields_of(beat_t b);
        return {b.uuid, b.wid, b.pc, b.tmask, b.rd, b.data, b.sop, b.eop};
    endfunction

    function automatic logic [DW-1:0] pack_beat(beat_t b);
        return {b.uuid, b.wid, b.pc, b.tmask, b.rd, b.wb, b.data, b.sop, b.eop};
    endfunction

    function automatic bit busy();
        for (int i = 0; i < NI; i++) begin
            if (uq[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic add_pkt(input int u, input int nb, input bit wb, input int gap0, input int gapn);
        beat_t b;
        for (int j = 0; j < nb; j++) begin
            b.uuid    = UW'({$urandom, $urandom});
            b.wid     = NW'($urandom);
            b.pc      = $urandom;
            b.tmask   = NT'($urandom);
            b.rd      = NR'($urandom);
            b.wb      = wb;
            b.data    = {$urandom, $urandom, $urandom, $urandom};
            b.sop     = (j == 0);
            b.eop     = (j == nb - 1);
            b.pre_gap = (j == 0) ? gap0 : gapn;
            uq[u].push_back(b);
        end
    endtask

    // One clock of stimulus plus the reference model's view of that cycle.
    task automatic cycle();
        int            g;
        logic [NI-1:0] exp_rdy;
        exp_t          e;
        beat_t         b;
        @(negedge clk);
        cyc   = cyc + 1;
        reset = rst_req;
        for (int i = 0; i < NI; i++) begin
            if (rst_req) begin
                uq[i].delete();
                pres[i] = 1'b0;
            end else if (!pres[i] && uq[i].size() > 0) begin
                if (uq[i][0].pre_gap > 0) uq[i][0].pre_gap = uq[i][0].pre_gap - 1;
                else pres[i] = 1'b1;
            end
            bus.in_valid[i] = rst_req ? 1'b1 : pres[i];
            bus.in_data[i*DW +: DW] = pres[i] ? pack_beat(uq[i][0])
                                              : DW'({$urandom, $urandom, $urandom, $urandom,
                                                     $urandom, $urandom, $urandom});
        end
        #1;
        g = -1;
        if (!rst_req) begin
            if (m_lock >= 0) begin
                if (pres[m_lock]) g = m_lock;
            end else begin
                for (int k = 0; k < NI; k++) begin
                    if (g < 0 && pres[(m_ptr + k) % NI]) g = (m_ptr + k) % NI;
                end
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        checks = checks + 1;
        if (bus.in_ready !== exp_rdy) begin
            failures = failures + 1;
            $display("FAIL in_ready cycle=%0d got=%b exp=%b", cyc, bus.in_ready, exp_rdy);
        end
        e.valid = 1'b0;
        if (rst_req) begin
            m_ptr    = 0;
            m_lock   = -1;
            m_retire = '0;
            m_last   = '0;
        end else if (g >= 0) begin
            b = uq[g].pop_front();
            pres[g] = 1'b0;
            if (b.eop) begin
                m_lock   = -1;
                m_ptr    = (g + 1) % NI;
                m_retire = m_retire + 1;
            end else begin
                m_lock = g;
            end
            if (b.wb) begin
                e.valid = 1'b1;
                m_last  = fields_of(b);
            end
        end
        e.f      = m_last;
        e.retire = m_retire;
        sbq.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 300) begin
            cycle();
            n = n + 1;
        end
        checks = checks + 1;
        if (busy()) begin
            failures = failures + 1;
            $display("FAIL drain_timeout cycle=%0d got=pending exp=empty", cyc);
        end
        cycle();
    endtask

    // Monitor: one expected entry per clock, compared just after the edge.
    initial begin
        exp_t          e;
        logic [FW-1:0] got_f;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                got_f = {bus.wb_uuid, bus.wb_wid, bus.wb_PC, bus.wb_tmask, bus.wb_rd,
                         bus.wb_data, bus.wb_sop, bus.wb_eop};
                checks = checks + 1;
                if (bus.wb_valid !== e.valid) begin
                    failures = failures + 1;
                    $display("FAIL wb_valid cycle=%0d got=%b exp=%b", cyc, bus.wb_valid, e.valid);
                end
                checks = checks + 1;
                if (got_f !== e.f) begin
                    failures = failures + 1;
                    $display("FAIL wb_fields cycle=%0d got=%h exp=%h", cyc, got_f, e.f);
                end
                checks = checks + 1;
                if (bus.retire_cnt !== e.retire) begin
                    failures = failures + 1;
                    $display("FAIL retire_cnt cycle=%0d got=%0d exp=%0d", cyc, bus.retire_cnt, e.retire);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        m_ptr    = 0;
        m_lock   = -1;
        m_retire = '0;
        m_last   = '0;
        reset    = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        for (int i = 0; i < NI; i++) pres[i] = 1'b0;

        // Reset held three cycles with every unit requesting.
        rst_req = 1'b1;
        repeat (3) cycle();
        rst_req = 1'b0;

        // Steady single-beat traffic on all units: 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++)
            for (int u = 0; u < NI; u++) add_pkt(u, 1, 1'b1, 0, 0);
        drain();

        // Unit 1 three-beat packet competing with unit 2.
        add_pkt(1, 3, 1'b1, 0, 0);
        add_pkt(2, 1, 1'b1, 0, 0);
        drain();

        // Unit 0 locked, drops valid for two cycles while 2 and 3 wait.
        add_pkt(0, 2, 1'b1, 0, 2);
        add_pkt(2, 1, 1'b1, 1, 0);
        add_pkt(3, 1, 1'b1, 1, 0);
        drain();

        // Unit 3 single beat without writeback.
        add_pkt(3, 1, 1'b0, 0, 0);
        uq[3][uq[3].size()-1].rd = NR'(5);
        drain();

        // Move the pointer off 0, lock unit 2 mid-packet, then reset.
        add_pkt(0, 1, 1'b1, 0, 0);
        drain();
        add_pkt(2, 3, 1'b1, 0, 0);
        cycle();
        cycle();
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0;
        add_pkt(0, 1, 1'b1, 0, 0);
        add_pkt(2, 1, 1'b1, 0, 0);
        drain();

        // Randomized traffic with mixed packet lengths, gaps and wb flags.
        repeat (600) begin
            for (int u = 0; u < NI; u++) begin
                if (uq[u].size() < 3 && $urandom_range(0, 3) == 0)
                    add_pkt(u, $urandom_range(1, 3), ($urandom_range(0, 3) != 0),
                            $urandom_range(0, 2), $urandom_range(0, 1));
            end
            cycle();
        end
        drain();

        repeat (3) @(posedge clk);
        #2;
        checks = checks + 1;
        if (sbq.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
